sensor_line_tx: RTL and testbench

//  Sensor-side line transmitter that generates the black/active line stream consumed by the black-level-correction block.

---
 rtl/sensor_line_tx_if.sv | 35 +++
 rtl/sensor_line_tx.sv | 195 +++++++++++++++++++
 tb/tb_sensor_line_tx.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_line_tx_if.sv
// sensor_line_tx_if
//  Control, configuration and pixel-stream bundle for sensor_line_tx.
//  slave  : transmitter side (takes controls/config, drives the pixel stream).
//  master : controller / consumer side (drives controls/config, sees the stream).
//  Signals:
//   i_start, i_stop, i_ready    run control and downstream ready
//   cfg_black_level, cfg_pattern, cfg_lines   per-run configuration
//   o_valid, odata, o_sol, o_eol  pixel beat with line framing
//   o_busy, o_done                run status
interface sensor_line_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  i_start;
    logic                  i_stop;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] cfg_black_level;
    logic [1:0]            cfg_pattern;
    logic [15:0]           cfg_lines;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] odata;
    logic                  o_sol;
    logic                  o_eol;
    logic                  o_busy;
    logic                  o_done;

    modport master (
        output i_start, i_stop, i_ready, cfg_black_level, cfg_pattern, cfg_lines,
        input  o_valid, odata, o_sol, o_eol, o_busy, o_done
    );

    modport slave (
        input  i_start, i_stop, i_ready, cfg_black_level, cfg_pattern, cfg_lines,
        output o_valid, odata, o_sol, o_eol, o_busy, o_done
    );
endinterface

// File: rtl/sensor_line_tx.sv
// sensor_line_tx
//  Generates the black/active line stream for the black-level-correction path.
//  Line layout by pixel index: lead pixel(s), BPN_L left black, READ_PIXEL active,
//  BPN_R right black, one trailing pad. Black = black level + masked LFSR noise;
//  active = black level + selected pattern. All stream outputs are registered.
//  Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  sensor_line_tx_if.slave (controls, config, pixel stream, status)
module sensor_line_tx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BPS_L      = 1,
    parameter int unsigned BPN_L      = 100,
    parameter int unsigned READ_PIXEL = 16,
    parameter int unsigned BPN_R      = 100,
    parameter int unsigned LINE_GAP   = 20,
    parameter int unsigned ACT_OFFSET = 64,
    parameter int unsigned NOISE_MASK = 32'h07
) (
    input  logic             clk,
    input  logic             rst,
    sensor_line_tx_if.slave  bus
);
    localparam int unsigned DW       = DATA_WIDTH;
    localparam int unsigned LINE_LEN = BPS_L + BPN_L + READ_PIXEL + BPN_R + 1;
    localparam int unsigned PIX_W    = $clog2(LINE_LEN + 1);
    localparam int unsigned GAP_W    = $clog2(LINE_GAP + 1);

    localparam logic [PIX_W-1:0] LEAD_END  = PIX_W'(BPS_L);
    localparam logic [PIX_W-1:0] ACT_START = PIX_W'(BPS_L + BPN_L);
    localparam logic [PIX_W-1:0] RB_START  = PIX_W'(BPS_L + BPN_L + READ_PIXEL);
    localparam logic [PIX_W-1:0] LAST_IDX  = PIX_W'(LINE_LEN - 1);
    localparam logic [PIX_W-1:0] LINE_END  = PIX_W'(LINE_LEN);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(LINE_GAP - 1);
    localparam logic [DW-1:0]    MASK      = DW'(NOISE_MASK);
    localparam logic [DW-1:0]    OFFSET    = DW'(ACT_OFFSET);
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t           r_state;
    logic [PIX_W-1:0] r_pix_cnt;
    logic [15:0]      r_line_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [15:0]      r_lfsr;
    logic             r_stop_pend;
    logic [DW-1:0]    r_black;
    logic [1:0]       r_pattern;
    logic [15:0]      r_lines;

    logic [15:0]      w_lfsr_next;
    logic [PIX_W-1:0] w_active_idx;
    logic             w_is_edge;
    logic             w_is_active;
    logic             w_is_black;
    logic [DW-1:0]    w_pix;
    logic             w_emit;
    logic             w_finish;

    // Add with clamp to full scale instead of wrapping.
    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DW] ? {DW{1'b1}} : s[DW-1:0];
    endfunction

    // Pixel value for the index held in r_pix_cnt, plus region decode.
    always_comb begin
        w_lfsr_next  = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
        w_active_idx = r_pix_cnt - ACT_START;
        w_is_edge    = (r_pix_cnt < LEAD_END) || (r_pix_cnt == LAST_IDX);
        w_is_active  = (r_pix_cnt >= ACT_START) && (r_pix_cnt < RB_START);
        w_is_black   = !w_is_edge && !w_is_active;
        w_pix        = '0;
        if (w_is_edge) begin
            w_pix = '0;
        end else if (w_is_active) begin
            case (r_pattern)
                2'b00:   w_pix = sat_add(r_black, OFFSET);
                2'b01:   w_pix = sat_add(r_black, DW'(w_active_idx));
                2'b10:   w_pix = r_lfsr[DW-1:0];
                default: w_pix = sat_add(r_black, r_line_cnt[DW-1:0]);
            endcase
        end else begin
            w_pix = sat_add(r_black, r_lfsr[DW-1:0] & MASK);
        end
    end

    // A beat goes out on the WAIT_RDY->SEND edge (index 0) and on every SEND
    // cycle until the counter passes the last index.
    always_comb begin
        w_emit = ((r_state == ST_WAIT_RDY) && bus.i_ready && !bus.i_stop) ||
                 ((r_state == ST_SEND) && (r_pix_cnt != LINE_END));
        w_finish = r_stop_pend || bus.i_stop ||
                   ((r_lines != 16'd0) && (r_line_cnt == r_lines));
    end

    // Control FSM with registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pix_cnt   <= '0;
            r_line_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_lfsr      <= LFSR_SEED;
            r_stop_pend <= 1'b0;
            r_black     <= '0;
            r_pattern   <= '0;
            r_lines     <= '0;
            bus.o_valid <= 1'b0;
            bus.odata   <= '0;
            bus.o_sol   <= 1'b0;
            bus.o_eol   <= 1'b0;
            bus.o_busy  <= 1'b0;
            bus.o_done  <= 1'b0;
        end else begin
            bus.o_valid <= 1'b0;
            bus.odata   <= '0;
            bus.o_sol   <= 1'b0;
            bus.o_eol   <= 1'b0;
            bus.o_done  <= 1'b0;

            if (((r_state == ST_SEND) || (r_state == ST_GAP)) && bus.i_stop) begin
                r_stop_pend <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start && !bus.i_stop) begin
                        r_state     <= ST_WAIT_RDY;
                        bus.o_busy  <= 1'b1;
                        r_black     <= bus.cfg_black_level;
                        r_pattern   <= bus.cfg_pattern;
                        r_lines     <= bus.cfg_lines;
                        r_lfsr      <= LFSR_SEED;
                        r_line_cnt  <= '0;
                        r_pix_cnt   <= '0;
                        r_stop_pend <= 1'b0;
                    end
                end
                ST_WAIT_RDY: begin
                    if (bus.i_stop) begin
                        r_state    <= ST_IDLE;
                        bus.o_busy <= 1'b0;
                        bus.o_done <= 1'b1;
                    end else if (bus.i_ready) begin
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (r_pix_cnt == LINE_END) begin
                        r_state    <= ST_GAP;
                        r_pix_cnt  <= '0;
                        r_line_cnt <= r_line_cnt + 16'd1;
                        // The cycle that leaves GAP (done or WAIT_RDY) is the
                        // last of the LINE_GAP idle cycles, so count from 1.
                        r_gap_cnt  <= GAP_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt >= GAP_LAST) begin
                        if (w_finish) begin
                            r_state     <= ST_IDLE;
                            bus.o_busy  <= 1'b0;
                            bus.o_done  <= 1'b1;
                            r_stop_pend <= 1'b0;
                        end else begin
                            r_state <= ST_WAIT_RDY;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Beat launch; LFSR only steps on black beats.
            if (w_emit) begin
                bus.o_valid <= 1'b1;
                bus.odata   <= w_pix;
                bus.o_sol   <= (r_pix_cnt == '0);
                bus.o_eol   <= (r_pix_cnt == LAST_IDX);
                r_pix_cnt   <= r_pix_cnt + PIX_W'(1);
                if (w_is_black) begin
                    r_lfsr <= w_lfsr_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_sensor_line_tx.sv
// Testbench for sensor_line_tx: expected beats are queued at run start and a
// negedge monitor pops and compares each valid beat.
module tb_sensor_line_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sensor_line_tx_if #(.DATA_WIDTH(8)) bus();
    sensor_line_tx #(.DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       sol;
        logic       eol;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_eol_cyc = 0;
    int          eol_count = 0;
    int          mon_beat = 0;
    logic [15:0] m_lfsr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic b;
        b = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {b, l[15:1]};
    endfunction

    // Expected line at default geometry: 0 lead, 1..100 black, 101..116 active,
    // 117..216 black, 217 pad.
    task automatic push_line(input int black, input int pat, input int line_idx);
        exp_t e;
        int   d;
        int   k;
        for (int p = 0; p < 218; p++) begin
            if (p == 0 || p == 217) begin
                d = 0;
            end else if (p <= 100 || p >= 117) begin
                d = sat8(black + int'(m_lfsr[2:0]));
                m_lfsr = lfsr_step(m_lfsr);
            end else begin
                k = p - 101;
                case (pat)
                    0:       d = sat8(black + 64);
                    1:       d = sat8(black + k);
                    2:       d = int'(m_lfsr[7:0]);
                    default: d = sat8(black + (line_idx & 255));
                endcase
            end
            e.data = 8'(d);
            e.sol  = (p == 0);
            e.eol  = (p == 217);
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bus.o_valid) begin
            if (bus.o_sol) mon_beat = 0;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat data=%0d sol=%0b eol=%0b", bus.odata, bus.o_sol, bus.o_eol);
            end else begin
                e = exp_q.pop_front();
                if (bus.odata !== e.data || bus.o_sol !== e.sol || bus.o_eol !== e.eol) begin
                    errors++;
                    $display("FAIL beat%0d got data=%0d sol=%0b eol=%0b want data=%0d sol=%0b eol=%0b",
                             mon_beat, bus.odata, bus.o_sol, bus.o_eol, e.data, e.sol, e.eol);
                end
            end
            if (bus.o_eol) begin
                last_eol_cyc = cyc;
                eol_count++;
            end
            mon_beat++;
        end
    end

    task automatic start_run(input int black, input int pat, input int lines, input int n_push);
        @(negedge clk);
        bus.cfg_black_level = 8'(black);
        bus.cfg_pattern     = 2'(pat);
        bus.cfg_lines       = 16'(lines);
        m_lfsr = 16'hACE1;
        for (int l = 0; l < n_push; l++) push_line(black, pat, l);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int bound);
        int n = 0;
        while (!bus.o_valid && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(bus.o_valid), 1);
    endtask

    task automatic wait_eol(input string nm, input int bound);
        int n = 0;
        while (!(bus.o_valid && bus.o_eol) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(bus.o_eol), 1);
    endtask

    task automatic wait_done(input string nm, input int bound);
        int n = 0;
        while (!bus.o_done && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(bus.o_done), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int run;
        int nv;
        int e0;
        bus.i_start = 1'b0;
        bus.i_stop = 1'b0;
        bus.i_ready = 1'b1;
        bus.cfg_black_level = 8'd0;
        bus.cfg_pattern = 2'd0;
        bus.cfg_lines = 16'd0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({bus.o_valid, bus.odata, bus.o_sol, bus.o_eol, bus.o_busy, bus.o_done}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full flat line, black 16.
        e0 = eol_count;
        start_run(16, 0, 1, 1);
        wait_valid("t2_first_valid", 10);
        run = 0;
        while (bus.o_valid && run < 400) begin
            run++;
            @(negedge clk);
        end
        check("t2_valid_run", run, 218);
        wait_done("t2_done", 100);
        check("t2_done_delay", cyc - last_eol_cyc, 20);
        check("t2_busy_at_done", 32'(bus.o_busy), 0);
        check("t2_queue_empty", exp_q.size(), 0);
        check("t2_lines", eol_count - e0, 1);

        // Async reset mid-SEND.
        start_run(16, 0, 1, 1);
        wait_valid("t1_valid", 10);
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("t1_outputs_in_reset", 32'({bus.o_valid, bus.odata, bus.o_sol, bus.o_eol, bus.o_busy}), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t1_idle_after_reset", 32'({bus.o_busy, bus.o_valid}), 0);

        // Ramp with saturation: active 250..255 then 255.
        start_run(250, 1, 1, 1);
        wait_done("t3_done", 400);
        check("t3_queue_empty", exp_q.size(), 0);

        // LFSR active pattern.
        start_run(16, 2, 1, 1);
        wait_done("tl_done", 400);
        check("tl_queue_empty", exp_q.size(), 0);

        // Three lines, line-index pattern, ready held low before line 2.
        e0 = eol_count;
        start_run(30, 3, 3, 3);
        wait_eol("t4_eol_line1", 300);
        bus.i_ready = 1'b0;
        nv = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.o_valid) nv++;
        end
        check("t4_no_beats_not_ready", nv, 0);
        check("t4_busy_waiting", 32'(bus.o_busy), 1);
        bus.i_ready = 1'b1;
        wait_done("t4_done", 1000);
        check("t4_lines", eol_count - e0, 3);
        check("t4_queue_empty", exp_q.size(), 0);

        // Continuous mode, stop at beat 50 of line 4.
        e0 = eol_count;
        start_run(200, 3, 0, 4);
        for (int i = 0; i < 3; i++) begin
            wait_eol("t5_eol", 300);
            @(negedge clk);
        end
        wait_valid("t5_line4_start", 60);
        repeat (50) @(negedge clk);
        bus.i_stop = 1'b1;
        @(negedge clk);
        bus.i_stop = 1'b0;
        wait_done("t5_done", 600);
        check("t5_done_delay", cyc - last_eol_cyc, 20);
        check("t5_lines", eol_count - e0, 4);
        check("t5_queue_empty", exp_q.size(), 0);
        repeat (30) @(negedge clk);
        check("t5_idle_after", 32'({bus.o_busy, bus.o_valid}), 0);

        // Start and stop together in IDLE.
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_stop = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_stop = 1'b0;
        @(negedge clk);
        check("t6_start_stop_idle", 32'({bus.o_busy, bus.o_valid}), 0);

        // Start while busy is ignored and config stays latched.
        e0 = eol_count;
        start_run(40, 0, 1, 1);
        wait_valid("t6_valid", 10);
        repeat (20) @(negedge clk);
        bus.cfg_black_level = 8'd100;
        bus.cfg_pattern = 2'd1;
        bus.cfg_lines = 16'd5;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        wait_done("t6_done", 400);
        check("t6_queue_empty", exp_q.size(), 0);
        repeat (300) @(negedge clk);
        check("t6_single_line", eol_count - e0, 1);
        check("t6_idle_end", 32'(bus.o_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
